// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module mdu #(
  parameter int unsigned Xlen = 32,
  parameter int unsigned CntW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_start_i,
  input  logic [2:0]      mdu_op_code_i,
  input  logic [Xlen-1:0] mdu_data1_i,
  input  logic [Xlen-1:0] mdu_data2_i,
  input  logic            mdu_flush_i,
  output logic            mdu_busy_o,
  output logic            mdu_valid_o,
  output logic [Xlen-1:0] mdu_res_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [Xlen-1:0] MinInt = {1'b1, {(Xlen-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*Xlen-1:0] acc_q, acc_d;
  logic [Xlen-1:0]   b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              valid_q, valid_d;
  logic [Xlen-1:0]   res_q, res_d;

  logic              sign1, sign2;
  logic [Xlen-1:0]   mag1, mag2;
  logic [Xlen:0]     mul_sum;
  logic [2*Xlen-1:0] mul_next;
  logic [Xlen:0]     rem_sh, rem_diff;
  logic [2*Xlen-1:0] div_next;
  logic [2*Xlen-1:0] prod_fix;
  logic [Xlen-1:0]   lo_fix, hi_fix;
  logic [Xlen-1:0]   fix_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*Xlen-1:0] fast_a, fast_b;
`endif

  // Operand signedness per op: MULH/DIV/REM both signed, MULHSU only rs1 signed.
  always_comb begin
    sign1 = mdu_data1_i[Xlen-1] & ((mdu_op_code_i == 3'd1) || (mdu_op_code_i == 3'd2) ||
                                   (mdu_op_code_i == 3'd4) || (mdu_op_code_i == 3'd6));
    sign2 = mdu_data2_i[Xlen-1] & ((mdu_op_code_i == 3'd1) || (mdu_op_code_i == 3'd4) ||
                                   (mdu_op_code_i == 3'd6));
    mag1  = sign1 ? (Xlen'(0) - mdu_data1_i) : mdu_data1_i;
    mag2  = sign2 ? (Xlen'(0) - mdu_data2_i) : mdu_data2_i;
  end

  // acc = {hi, lo}; multiply shifts the multiplier out of lo, divide shifts the dividend out.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*Xlen-1:Xlen]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[Xlen-1:1]};
    rem_sh   = {acc_q[2*Xlen-1:Xlen], acc_q[Xlen-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (!rem_diff[Xlen]) begin
      div_next = {rem_diff[Xlen-1:0], acc_q[Xlen-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[Xlen-1:0], acc_q[Xlen-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q ? ((2*Xlen)'(0) - acc_q) : acc_q;
    lo_fix   = neg_q ? (Xlen'(0) - acc_q[Xlen-1:0]) : acc_q[Xlen-1:0];
    hi_fix   = neg_q ? (Xlen'(0) - acc_q[2*Xlen-1:Xlen]) : acc_q[2*Xlen-1:Xlen];
    unique case (op_q)
      3'd0:                fix_res = prod_fix[Xlen-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*Xlen-1:Xlen];
      3'd4, 3'd5:          fix_res = lo_fix;
      default:             fix_res = hi_fix;
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  always_comb begin
    fast_a = {{Xlen{sign1}}, mdu_data1_i};
    fast_b = {{Xlen{sign2}}, mdu_data2_i};
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    valid_d = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_start_i && !mdu_flush_i) begin
          op_d    = mdu_op_code_i;
          acc_d   = {{Xlen{1'b0}}, mag1};
          b_d     = mag2;
          cnt_d   = '0;
          neg_d   = (mdu_op_code_i[2] && mdu_op_code_i[1]) ? sign1 : (sign1 ^ sign2);
          state_d = StCalc;
          // Special results are preloaded as {remainder, quotient} with no sign fix-up.
          if (mdu_op_code_i[2]) begin
            if (mdu_data2_i == '0) begin
              acc_d   = {mdu_data1_i, {Xlen{1'b1}}};
              neg_d   = 1'b0;
              state_d = StDone;
            end else if (!mdu_op_code_i[0] && (mdu_data1_i == MinInt) &&
                         (mdu_data2_i == {Xlen{1'b1}})) begin
              acc_d   = {{Xlen{1'b0}}, MinInt};
              neg_d   = 1'b0;
              state_d = StDone;
            end
          end
`ifdef MDU_FAST_MUL_EN
          else begin
            acc_d   = fast_a * fast_b;
            neg_d   = 1'b0;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (mdu_flush_i) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = op_q[2] ? div_next : mul_next;
          if (cnt_q == CntW'(Xlen - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!mdu_flush_i) begin
          valid_d = 1'b1;
          res_d   = fix_res;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign mdu_busy_o  = (state_q != StIdle);
  assign mdu_valid_o = valid_q;
  assign mdu_res_o   = res_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic RV32M reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic        flush;
  logic        busy, valid;
  logic [31:0] res;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_exp = 32'h0;

  mdu dut (
    .clk          (clk),
    .rst          (rst),
    .mdu_start_i  (start),
    .mdu_op_code_i(op),
    .mdu_data1_i  (d1),
    .mdu_data2_i  (d2),
    .mdu_flush_i  (flush),
    .mdu_busy_o   (busy),
    .mdu_valid_o  (valid),
    .mdu_res_o    (res)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] pa, pb, p;
    int          sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin pa = {32'h0, a}; pb = {32'h0, b}; p = pa * pb; return p[31:0]; end
      3'd1: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; p = pa * pb; return p[63:32]; end
      3'd2: begin pa = {{32{a[31]}}, a}; pb = {32'h0, b}; p = pa * pb; return p[63:32]; end
      3'd3: begin pa = {32'h0, a}; pb = {32'h0, b}; p = pa * pb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o >= 3'd4 && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (o <= 3'd3) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and follows it to its valid pulse; poke_at > 0 re-pulses start while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
    int          lat;
    bit          busy_ok;
    logic [31:0] exp;
    exp     = model(o, a, b);
    lat     = 0;
    busy_ok = 1'b1;
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); d1 = $urandom; d2 = $urandom;
    if (!busy) busy_ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (valid) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (n == poke_at) begin
        start = 1'b1; op = 3'($urandom); d1 = $urandom; d2 = $urandom;
      end
    end
    start = 1'b0;
    check_eq($sformatf("latency op%0d", o), 64'(lat), 64'(exp_latency(o, a, b)));
    check_eq($sformatf("res op%0d %h,%h", o, a, b), {32'h0, res}, {32'h0, exp});
    check_eq("busy during op", {63'h0, busy_ok}, 64'h1);
    check_eq("busy low at valid", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    check_eq("valid one cycle", {63'h0, valid}, 64'h0);
    last_exp = exp;
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    check_eq(tag, 64'(seen), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; d1 = 32'h0; d2 = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", {63'h0, busy}, 64'h0);
    check_eq("reset valid", {63'h0, valid}, 64'h0);
    check_eq("reset res", {32'h0, res}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check_eq("mul 7*-3", {32'h0, res}, {32'h0, 32'hFFFF_FFEB});
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush ten cycles into CALC.
    start = 1'b1; op = 3'd4; d1 = 32'd1000; d2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush busy", {63'h0, busy}, 64'h0);
    check_eq("flush valid", {63'h0, valid}, 64'h0);
    check_eq("flush res held", {32'h0, res}, {32'h0, last_exp});
    watch_no_valid("flush no pulse", 40);
    run_op(3'd5, 32'd9, 32'd3, 0);

    // Flush during the DONE cycle of a special case.
    start = 1'b1; op = 3'd5; d1 = 32'd5; d2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("done-flush busy", {63'h0, busy}, 64'h0);
    check_eq("done-flush res held", {32'h0, res}, {32'h0, last_exp});
    watch_no_valid("done-flush no pulse", 5);

    // Start together with flush is ignored.
    start = 1'b1; flush = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("start+flush ignored", {63'h0, busy}, 64'h0);
    watch_no_valid("start+flush no pulse", 3);

    run_op(3'd0, 32'd123, 32'd456, 5);
    run_op(3'd6, 32'hFFFF_0000, 32'd77, 12);

    // Reset in the middle of CALC.
    start = 1'b1; op = 3'd1; d1 = 32'h1234_5678; d2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst busy", {63'h0, busy}, 64'h0);
    check_eq("midrst valid", {63'h0, valid}, 64'h0);
    check_eq("midrst res", {32'h0, res}, 64'h0);
    watch_no_valid("midrst no pulse", 40);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
